col_readout_arb: RTL and testbench
==================================

COL_READOUT_ARB -- requirements
Module: col_readout_arb

Interface
REQ-001 SHALL have parameter N_COLS, default 56: number of columns; range 2..64.
REQ-002 SHALL have parameter DATA_W, default 21: column data width.
REQ-003 SHALL have parameter BCID_W, default 6: timestamp counter width.
REQ-004 SHALL have parameter FIFO_DEPTH, default 8: output buffer depth, power of two, at least 2; derived ADDR_W = clog2(N_COLS).
REQ-005 SHALL have one clock and an asynchronous active-low reset: ClkBx  in  1  sole clock, rising edge; ResetB  in  1  asynchronous, active-low reset.
REQ-006 Enable  in  N_COLS  per-column enable.
REQ-007 TokColB  in  N_COLS  active-low column token; 0 means hit pending.
REQ-008 DataCol  in  N_COLS*DATA_W  column data; column i occupies bits [i*DATA_W +: DATA_W].
REQ-009 ReadCol  out  N_COLS  one-cycle read strobe per column.
REQ-010 FreezeCol  out  N_COLS  freeze to columns.
REQ-011 BcidOut  out  BCID_W  broadcast timestamp.
REQ-012 DataOut  out  ADDR_W+DATA_W  output word {column address, column data}.
REQ-013 DataValid  out  1  and  DataReady  in  1  output handshake.
REQ-014 TokenOut  out  1  high while any enabled column is pending or the FIFO is non-empty.
REQ-015 Overflow  out  1  sticky; set on a test-pattern push attempt while the FIFO is full.

Function
REQ-016 pend[i] SHALL be ~TokColB[i] & Enable[i]; disabled columns SHALL never be frozen, read or reported.
REQ-017 BcidOut SHALL increment by 1 on every ClkBx edge and wrap from 2^BCID_W-1 to 0.
REQ-018 The FSM SHALL have states IDLE, FREEZE, SCAN, READ and SETTLE.
REQ-019 IDLE: if any pend -> FREEZE; otherwise stay in IDLE.
REQ-020 FREEZE: FreezeCol = Enable from this state until return to IDLE; the FSM SHALL go unconditionally -> SCAN.
REQ-021 SCAN: select the lowest-index pending column; no pend -> IDLE with FreezeCol = 0; FIFO full -> stay in SCAN (stall); otherwise -> READ.
REQ-022 READ: ReadCol[sel] = 1 for exactly this cycle; on the closing edge, push {sel[ADDR_W-1:0], DataCol[sel]} into the FIFO; the FSM SHALL then go -> SETTLE.
REQ-023 SETTLE: one cycle allowing the column token to update; the FSM SHALL then go -> SCAN.
REQ-024 At most one ReadCol bit SHALL be high in any cycle; the cost SHALL be 3 cycles per hit at steady state.
REQ-025 The selected column SHALL be latched on entry to READ; changes on TokColB during READ or SETTLE SHALL not alter that push.
REQ-026 A column asserting its token after the freeze SHALL be served within the same scan if still pending at a SCAN decision.
REQ-027 FIFO: DataValid = non-empty; DataOut = head word; DataOut = 0 when empty.
REQ-028 A pop SHALL occur when DataValid & DataReady.
REQ-029 Latency from push edge to DataValid high SHALL be 1 cycle.
REQ-030 Simultaneous push and pop SHALL keep the occupancy count unchanged; when full, push eligibility SHALL use the count before the pop (no bypass).
REQ-031 FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-032 Word order SHALL be strictly push order.

Reset
REQ-033 While ResetB = 0: FSM = IDLE; FIFO empty; ReadCol = 0; FreezeCol = 0; BcidOut = 0; DataOut = 0; DataValid = 0; TokenOut = 0; Overflow = 0; test counter = 0.
REQ-034 Reset asserted mid-scan SHALL abort immediately, discard FIFO contents and produce no further ReadCol pulse.
REQ-035 After reset release, the first BcidOut increment SHALL occur on the first ClkBx edge.

Configuration
REQ-036 With macro COL_READOUT_TEST_PATTERN_EN defined: the block SHALL add input port EnTestPattern (1 bit).
REQ-037 With the macro defined and EnTestPattern = 1: the FSM SHALL be held in IDLE with FreezeCol = 0 and ReadCol = 0.
REQ-038 With the macro defined and EnTestPattern = 1: each cycle the FIFO is not full, the block SHALL push {all-ones address, counter}; the DATA_W counter SHALL start at 0 and increment per push.
REQ-039 With the macro defined and EnTestPattern = 1: a push attempt on a full FIFO SHALL set Overflow.
REQ-040 Without the macro: no EnTestPattern port; behaviour SHALL be identical to EnTestPattern = 0; Overflow SHALL be constant 0.

Verification
REQ-041 Columns 3 and 10 pending, DataReady = 1 -> FreezeCol = Enable; ReadCol[3] and then ReadCol[10] 3 cycles apart; words {3,D3} then {10,D10}; IDLE afterwards with FreezeCol = 0.
REQ-042 Column 5 pending with Enable[5] = 0 -> FSM stays in IDLE; no ReadCol; TokenOut = 0.
REQ-043 DataReady = 0 with 12 hits and FIFO_DEPTH = 8 -> exactly 8 reads, then a SCAN stall; raising DataReady resumes with the remaining 4 words in order, with none lost and Overflow = 0.
REQ-044 ResetB pulled low during READ of column 7 -> all outputs at reset values on the same cycle; after release, column 7 still pending is read afresh.
REQ-045 Run 2^BCID_W + 3 cycles -> BcidOut = 3.
REQ-046 With macro defined, EnTestPattern = 1 and DataReady = 0 -> 8 words with data 0..7; Overflow = 1 on the 9th cycle; no ReadCol pulses.

Source files
------------

// File: rtl/col_readout_arb.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : col_readout_arb
// Summary  : Freeze-and-scan column token arbiter feeding a small output FIFO.
//            Optional test-pattern source enabled by COL_READOUT_TEST_PATTERN_EN.
// Revision : 1.0  initial release
// ============================================================================
module col_readout_arb #(
    parameter int N_COLS     = 56,
    parameter int DATA_W     = 21,
    parameter int BCID_W     = 6,
    parameter int FIFO_DEPTH = 8,
    localparam int ADDR_W    = $clog2(N_COLS)
) (
    input  logic                       ClkBx,
    input  logic                       ResetB,
    input  logic [N_COLS-1:0]          Enable,
    input  logic [N_COLS-1:0]          TokColB,
    input  logic [N_COLS*DATA_W-1:0]   DataCol,
    output logic [N_COLS-1:0]          ReadCol,
    output logic [N_COLS-1:0]          FreezeCol,
    output logic [BCID_W-1:0]          BcidOut,
    output logic [ADDR_W+DATA_W-1:0]   DataOut,
    output logic                       DataValid,
    input  logic                       DataReady,
    output logic                       TokenOut,
`ifdef COL_READOUT_TEST_PATTERN_EN
    input  logic                       EnTestPattern,
`endif
    output logic                       Overflow
);

    localparam int                  c_word_w = ADDR_W + DATA_W;
    localparam int                  c_ptr_w  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [c_ptr_w:0]    c_depth  = (c_ptr_w+1)'(FIFO_DEPTH);
    localparam logic [N_COLS-1:0]   c_one    = {{(N_COLS-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FREEZE = 3'd1,
        S_SCAN   = 3'd2,
        S_READ   = 3'd3,
        S_SETTLE = 3'd4
    } state_t;

    state_t                 r_state;
    logic [N_COLS-1:0]      r_read;
    logic [N_COLS-1:0]      r_freeze;
    logic [ADDR_W-1:0]      r_sel;
    logic [BCID_W-1:0]      r_bcid;

    logic [c_word_w-1:0]    r_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0]     r_wr_ptr;
    logic [c_ptr_w-1:0]     r_rd_ptr;
    logic [c_ptr_w:0]       r_count;

    logic [N_COLS-1:0]      w_pend;
    logic                   w_any_pend;
    logic [ADDR_W-1:0]      w_sel;
    logic [DATA_W-1:0]      w_sel_data;
    logic                   w_full;
    logic                   w_pop;
    logic                   w_push;
    logic                   w_tp_en;
    logic [c_word_w-1:0]    w_push_word;

    assign w_pend     = ~TokColB & Enable;
    assign w_any_pend = |w_pend;
    assign w_full     = (r_count == c_depth);
    assign DataValid  = (r_count != '0);
    assign w_pop      = DataValid & DataReady;

    // Lowest-index pending column wins the scan decision.
    always_comb begin
        w_sel = '0;
        for (int i = N_COLS - 1; i >= 0; i--) begin
            if (w_pend[i]) begin
                w_sel = ADDR_W'(i);
            end
        end
    end

    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < N_COLS; i++) begin
            if (r_sel == ADDR_W'(i)) begin
                w_sel_data = DataCol[i*DATA_W +: DATA_W];
            end
        end
    end

`ifdef COL_READOUT_TEST_PATTERN_EN
    logic [DATA_W-1:0]      r_tp_cnt;
    logic                   r_ovf;

    assign w_tp_en     = EnTestPattern;
    assign w_push_word = w_tp_en ? {{ADDR_W{1'b1}}, r_tp_cnt} : {r_sel, w_sel_data};
    assign Overflow    = r_ovf;

    always_ff @(posedge ClkBx or negedge ResetB) begin
        if (!ResetB) begin
            r_tp_cnt <= '0;
            r_ovf    <= 1'b0;
        end else if (w_tp_en) begin
            if (w_full) begin
                r_ovf <= 1'b1;
            end else begin
                r_tp_cnt <= r_tp_cnt + 1'b1;
            end
        end
    end
`else
    assign w_tp_en     = 1'b0;
    assign w_push_word = {r_sel, w_sel_data};
    assign Overflow    = 1'b0;
`endif

    // Column words land on the edge closing READ; test words whenever room exists.
    assign w_push = !w_full && (w_tp_en || (r_state == S_READ));

    always_ff @(posedge ClkBx or negedge ResetB) begin
        if (!ResetB) begin
            r_state  <= S_IDLE;
            r_read   <= '0;
            r_freeze <= '0;
            r_sel    <= '0;
        end else if (w_tp_en) begin
            r_state  <= S_IDLE;
            r_read   <= '0;
            r_freeze <= '0;
        end else begin
            r_read <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_any_pend) begin
                        r_state  <= S_FREEZE;
                        r_freeze <= Enable;
                    end
                end
                S_FREEZE: begin
                    r_state  <= S_SCAN;
                    r_freeze <= Enable;
                end
                S_SCAN: begin
                    if (!w_any_pend) begin
                        r_state  <= S_IDLE;
                        r_freeze <= '0;
                    end else begin
                        r_freeze <= Enable;
                        if (!w_full) begin
                            r_state <= S_READ;
                            r_sel   <= w_sel;
                            r_read  <= c_one << w_sel;
                        end
                    end
                end
                S_READ: begin
                    r_state  <= S_SETTLE;
                    r_freeze <= Enable;
                end
                S_SETTLE: begin
                    r_state  <= S_SCAN;
                    r_freeze <= Enable;
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_freeze <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge ClkBx or negedge ResetB) begin
        if (!ResetB) begin
            r_bcid <= '0;
        end else begin
            r_bcid <= r_bcid + 1'b1;
        end
    end

    always_ff @(posedge ClkBx or negedge ResetB) begin
        if (!ResetB) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge ClkBx) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_push_word;
        end
    end

    assign ReadCol   = r_read;
    assign FreezeCol = r_freeze;
    assign BcidOut   = r_bcid;
    assign DataOut   = DataValid ? r_mem[r_rd_ptr] : '0;
    assign TokenOut  = ResetB & (w_any_pend | DataValid);

    a_read_onehot: assert property (@(posedge ClkBx) disable iff (!ResetB) $onehot0(ReadCol));
    a_count_bound: assert property (@(posedge ClkBx) disable iff (!ResetB) r_count <= c_depth);

endmodule

`default_nettype wire

// File: tb/tb_col_readout_arb.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_col_readout_arb
// Summary  : Randomized bench for col_readout_arb with a column/scoreboard model.
// Revision : 1.0  initial release
// ============================================================================
module tb_col_readout_arb;

    localparam int N     = 56;
    localparam int DW    = 21;
    localparam int BW    = 6;
    localparam int DEPTH = 8;
    localparam int AW    = $clog2(N);
    localparam int WW    = AW + DW;

    logic            ClkBx = 1'b0;
    logic            ResetB;
    logic [N-1:0]    Enable;
    logic [N-1:0]    TokColB;
    logic [N*DW-1:0] DataCol;
    logic [N-1:0]    ReadCol;
    logic [N-1:0]    FreezeCol;
    logic [BW-1:0]   BcidOut;
    logic [WW-1:0]   DataOut;
    logic            DataValid;
    logic            DataReady;
    logic            TokenOut;
    logic            Overflow;
`ifdef COL_READOUT_TEST_PATTERN_EN
    logic            EnTestPattern;
`endif

    col_readout_arb #(
        .N_COLS     (N),
        .DATA_W     (DW),
        .BCID_W     (BW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .ClkBx     (ClkBx),
        .ResetB    (ResetB),
        .Enable    (Enable),
        .TokColB   (TokColB),
        .DataCol   (DataCol),
        .ReadCol   (ReadCol),
        .FreezeCol (FreezeCol),
        .BcidOut   (BcidOut),
        .DataOut   (DataOut),
        .DataValid (DataValid),
        .DataReady (DataReady),
        .TokenOut  (TokenOut),
`ifdef COL_READOUT_TEST_PATTERN_EN
        .EnTestPattern (EnTestPattern),
`endif
        .Overflow  (Overflow)
    );

    always #5 ClkBx = ~ClkBx;

    // Column model: each column holds a count of queued hits and the data of the current one.
    int              hits     [N];
    logic [DW-1:0]   col_data [N];
    logic [WW-1:0]   exp_q [$];
    logic [WW-1:0]   pop_log [$];
    int              rd_col [$];
    int              rd_cyc [$];
    int              cyc;
    int              bcnt;
    int              consume_col = -1;
    logic [N-1:0]    pend_prev;
    logic [N-1:0]    en_prev;
    bit              tp_mode;
    int              n_vec;
    int              n_err;

    logic [N-1:0]    m_pend;
    int              m_c;
    logic [WW-1:0]   tmpw;

    always_comb begin
        TokColB = '1;
        DataCol = '0;
        for (int i = 0; i < N; i++) begin
            TokColB[i]            = (hits[i] == 0);
            DataCol[i*DW +: DW]   = col_data[i];
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int lowest(input logic [N-1:0] v);
        int r;
        r = N;
        for (int i = N - 1; i >= 0; i--) begin
            if (v[i]) r = i;
        end
        return r;
    endfunction

    // Cycles since reset release; the timestamp is this modulo 2^BW.
    always @(posedge ClkBx or negedge ResetB) begin
        if (!ResetB) bcnt <= 0;
        else         bcnt <= bcnt + 1;
    end

    // A read column drops its current hit after the sampling edge.
    always @(posedge ClkBx) begin
        #1;
        if (consume_col >= 0 && ResetB) begin
            hits[consume_col]     = hits[consume_col] - 1;
            col_data[consume_col] = DW'($urandom);
        end
        consume_col = -1;
    end

    always @(negedge ClkBx) begin
        cyc++;
        m_pend = ~TokColB & Enable;
        if (!ResetB) begin
            check("rst_readcol", ReadCol, '0);
            check("rst_freeze", FreezeCol, '0);
            check("rst_bcid", BcidOut, '0);
            check("rst_valid", DataValid, 1'b0);
            check("rst_dout", DataOut, '0);
            check("rst_token", TokenOut, 1'b0);
            check("rst_ovf", Overflow, 1'b0);
            exp_q.delete();
            pend_prev = '0;
            en_prev   = '0;
        end else begin
            check("bcid", BcidOut, 64'(bcnt % (1 << BW)));
            if (!tp_mode) begin
                check("valid", DataValid, exp_q.size() != 0);
                check("token", TokenOut, (m_pend != '0) || (exp_q.size() != 0));
                check("ovf", Overflow, 1'b0);
                if (!DataValid) begin
                    check("dout_empty", DataOut, '0);
                end else if (DataReady && exp_q.size() != 0) begin
                    tmpw = exp_q.pop_front();
                    check("dout", DataOut, tmpw);
                    pop_log.push_back(DataOut);
                end
            end
            check("freeze", (FreezeCol == '0) || (FreezeCol == en_prev), 1'b1);
            if (ReadCol != '0) begin
                m_c = lowest(ReadCol);
                check("rd_onehot", $countones(ReadCol), 1);
                check("rd_arb", m_c, lowest(pend_prev));
                check("rd_freeze", FreezeCol, en_prev);
                exp_q.push_back({m_c[AW-1:0], col_data[m_c]});
                rd_col.push_back(m_c);
                rd_cyc.push_back(cyc);
                consume_col = m_c;
            end
            pend_prev = m_pend;
            en_prev   = Enable;
        end
    end

    task automatic tick();
        @(posedge ClkBx);
        #2;
    endtask

    task automatic sample();
        @(negedge ClkBx);
        #1;
    endtask

    task automatic add_hit(input int c);
        if (hits[c] == 0) col_data[c] = DW'($urandom);
        hits[c] = hits[c] + 1;
    endtask

    task automatic do_reset();
        ResetB = 1'b0;
        repeat (3) tick();
        ResetB = 1'b1;
    endtask

    task automatic wait_idle(input int max_cyc, input string tag);
        bit done;
        done = 1'b0;
        for (int k = 0; k < max_cyc && !done; k++) begin
            sample();
            if (TokenOut == 1'b0 && FreezeCol == '0) done = 1'b1;
        end
        check(tag, done, 1'b1);
    endtask

    int              base_rd;
    int              base_pop;
    int              c;
    int              sum;
    int              cols [$];
    logic [DW-1:0]   d3, d10, d7;
    bit              got;

    initial begin
        ResetB    = 1'b0;
        Enable    = '1;
        DataReady = 1'b0;
        tp_mode   = 1'b0;
        n_vec     = 0;
        n_err     = 0;
        cyc       = 0;
`ifdef COL_READOUT_TEST_PATTERN_EN
        EnTestPattern = 1'b0;
`endif
        for (int i = 0; i < N; i++) begin
            hits[i]     = 0;
            col_data[i] = '0;
        end

        repeat (3) tick();
        ResetB = 1'b1;
        repeat (67) @(posedge ClkBx);
        @(negedge ClkBx);
        #1;
        check("bcid_wrap", BcidOut, 3);

`ifdef COL_READOUT_TEST_PATTERN_EN
        tp_mode = 1'b1;
        tick();
        EnTestPattern = 1'b1;
        repeat (8) @(posedge ClkBx);
        sample();
        check("tp_full", DataValid, 1'b1);
        check("tp_ovf0", Overflow, 1'b0);
        @(posedge ClkBx);
        sample();
        check("tp_ovf1", Overflow, 1'b1);
        check("tp_noread", ReadCol, '0);
        tick();
        EnTestPattern = 1'b0;
        DataReady     = 1'b1;
        for (int k = 0; k < 8; k++) begin
            sample();
            tmpw = {{AW{1'b1}}, DW'(k)};
            check("tp_word", DataOut, tmpw);
        end
        sample();
        check("tp_empty", DataValid, 1'b0);
        tick();
        DataReady = 1'b0;
        do_reset();
        tp_mode = 1'b0;
`endif

        // Two pending columns, drained in index order three cycles apart.
        tick();
        DataReady = 1'b1;
        Enable    = N'({$urandom(), $urandom()});
        Enable[3]  = 1'b1;
        Enable[10] = 1'b1;
        base_rd  = rd_col.size();
        base_pop = pop_log.size();
        add_hit(10);
        add_hit(3);
        d3  = col_data[3];
        d10 = col_data[10];
        wait_idle(40, "t41_idle");
        check("t41_nrd", rd_col.size() - base_rd, 2);
        check("t41_first", rd_col[base_rd], 3);
        check("t41_second", rd_col[base_rd+1], 10);
        check("t41_gap", rd_cyc[base_rd+1] - rd_cyc[base_rd], 3);
        check("t41_npop", pop_log.size() - base_pop, 2);
        check("t41_word0", pop_log[base_pop], {6'd3, d3});
        check("t41_word1", pop_log[base_pop+1], {6'd10, d10});
        check("t41_frz_idle", FreezeCol, '0);

        // A disabled column is invisible.
        tick();
        Enable    = '1;
        Enable[5] = 1'b0;
        base_rd   = rd_col.size();
        add_hit(5);
        repeat (10) sample();
        check("t42_nrd", rd_col.size() - base_rd, 0);
        check("t42_token", TokenOut, 1'b0);
        check("t42_freeze", FreezeCol, '0);
        tick();
        hits[5] = 0;
        Enable  = '1;

        // Twelve hits against a stalled consumer: eight reads, then resume in order.
        DataReady = 1'b0;
        cols.delete();
        while (cols.size() < 12) begin
            c = $urandom_range(N - 1);
            if (hits[c] == 0) begin
                cols.push_back(c);
                add_hit(c);
            end
        end
        cols.sort();
        base_rd  = rd_col.size();
        base_pop = pop_log.size();
        repeat (60) sample();
        check("t43_nrd8", rd_col.size() - base_rd, 8);
        check("t43_valid", DataValid, 1'b1);
        check("t43_token", TokenOut, 1'b1);
        tick();
        DataReady = 1'b1;
        wait_idle(200, "t43_idle");
        check("t43_nrd12", rd_col.size() - base_rd, 12);
        check("t43_npop", pop_log.size() - base_pop, 12);
        for (int k = 0; k < 12 && (base_pop + k) < pop_log.size(); k++) begin
            tmpw = pop_log[base_pop+k];
            check("t43_order", tmpw[WW-1:DW], cols[k]);
        end
        check("t43_ovf", Overflow, 1'b0);

        // Reset while column 7 is being read.
        tick();
        add_hit(7);
        d7  = col_data[7];
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge ClkBx);
            if (ReadCol[7]) got = 1'b1;
        end
        check("t44_seen", got, 1'b1);
        #1;
        ResetB = 1'b0;
        #1;
        check("t44_readcol", ReadCol, '0);
        check("t44_freeze", FreezeCol, '0);
        check("t44_valid", DataValid, 1'b0);
        check("t44_dout", DataOut, '0);
        check("t44_token", TokenOut, 1'b0);
        check("t44_bcid", BcidOut, '0);
        repeat (3) tick();
        check("t44_pending", hits[7], 1);
        base_rd  = rd_col.size();
        base_pop = pop_log.size();
        ResetB = 1'b1;
        wait_idle(40, "t44_idle");
        check("t44_nrd", rd_col.size() - base_rd, 1);
        check("t44_col", (rd_col.size() > base_rd) ? rd_col[base_rd] : -1, 7);
        check("t44_word", (pop_log.size() > base_pop) ? pop_log[base_pop] : '0, {6'd7, d7});

        // Random traffic with bursts, late arrivals and enable changes.
        tick();
        Enable = '1;
        for (int t = 0; t < 1500; t++) begin
            tick();
            DataReady = ($urandom_range(9) < 7);
            if ($urandom_range(3) == 0) begin
                c = ($urandom_range(3) == 0) ? $urandom_range(7) : $urandom_range(N - 1);
                if (hits[c] < 3) add_hit(c);
            end
            if ($urandom_range(99) == 0) begin
                Enable = N'({$urandom(), $urandom()} | {$urandom(), $urandom()});
            end
        end
        tick();
        Enable    = '1;
        DataReady = 1'b1;
        wait_idle(2000, "drain_idle");
        check("drain_queue", exp_q.size(), 0);
        sum = 0;
        for (int i = 0; i < N; i++) sum += hits[i];
        check("drain_hits", sum, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule

`default_nettype wire
